csa_accum_ctrl: RTL and testbench
=================================

// Module: csa_accum_ctrl
// PURPOSE
//  Sequencer that sums a stream of WIDTH-bit operands using carry-save accumulation.
//  Partial state is a redundant (sum, carry) vector pair; one 3:2 full-adder row runs per operand.
//  On the last operand it resolves the pair by iterative carry-propagate add, then presents the result.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//  WIDTH  4  operand width in bits
//  ACC_W  8  accumulator/result width in bits (>= WIDTH); all arithmetic is mod 2^ACC_W
//  CNT_W  8  operand-counter width (used only when CSA_CNT_EN is defined)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operand valid
//  in_ready   out  1      controller can accept an operand
//  in_data    in   WIDTH  operand, zero-extended to ACC_W bits
//  in_last    in   1      marks the final operand of a group; qualified by the handshake
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  out_data   out  ACC_W  resolved sum of the group, mod 2^ACC_W
//  out_cnt    out  CNT_W  operands in the group (present only with CSA_CNT_EN)
// BEHAVIOUR
//  States: IDLE, ACCUM, RESOLVE, DONE. Registers: s[ACC_W], c[ACC_W], state.
//  Reset (asynchronous, any state): state=IDLE, s=0, c=0, out_valid=0, out_data=0, out_cnt=0.
//    Any partial group is discarded.
//  in_ready = 1 in IDLE and ACCUM; 0 in RESOLVE and DONE.
//  Accept = in_valid & in_ready, sampled at the clock edge. With x = zext(in_data):
//    IDLE:  s <= x; c <= 0 (previous group cleared).
//    ACCUM: s <= s^c^x; c <= ((s&c)|(s&x)|(c&x)) << 1. The bit shifted out of MSB is dropped.
//  Accept with in_last=0 -> ACCUM. Accept with in_last=1 -> RESOLVE.
//    A single-operand group goes IDLE->RESOLVE.
//  RESOLVE, at each edge:
//    if c==0 -> DONE;
//    else s <= s^c, c <= (s&c) << 1 and stay in RESOLVE.
//    Takes 1..ACC_W+1 edges; never exceeds ACC_W+1 edges.
//  DONE:
//    out_valid = 1 and out_data = s, held stable while out_ready=0.
//    out_valid & out_ready at an edge -> IDLE with out_valid=0. out_data retains its value.
//  out_valid is registered. No combinational path from in_* or out_ready to any output
//    except in_ready (state-decoded only).
//  in_valid in RESOLVE/DONE is ignored (in_ready=0). in_last outside a handshake is ignored.
//  Wrap-around: overflow past 2^ACC_W wraps silently. No flag is raised.
// CONFIGURATION
//  CSA_CNT_EN defined:
//    out_cnt port exists.
//    Counter loads 1 on an IDLE accept and increments on each ACCUM accept.
//    Saturates at 2^CNT_W-1.
//    out_cnt is valid with out_valid and held in DONE.
//  CSA_CNT_EN undefined: out_cnt port and counter are absent; all other behaviour is identical.
// TESTING
//  (ACC_W=8, WIDTH=4)
//  1. Operands 3, 5, 7(last), no stalls -> out_data=15.
//     out_valid rises 2 edges after the last handshake. out_cnt=3.
//  2. Single operand 9 with in_last=1 -> c==0, so DONE after 1 edge. out_data=9, out_cnt=1.
//  3. Eighteen operands of 15, last on the 18th -> out_data=14 (270 mod 256).
//     RESOLVE completes within 9 edges. out_cnt=18.
//  4. Result pending with out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0 throughout;
//     out_data is stable. out_ready=1 -> IDLE, then new group 1, 2(last) -> 3.
//  5. rst pulsed mid-ACCUM, after 2, 4 -> outputs 0, IDLE. Then 6(last) -> out_data=6, out_cnt=1.
//  6. Random groups of 1..40 operands with random valid/ready stalls -> out_data matches
//     reference sum mod 256; RESOLVE duration <= 9 edges.

Source files
------------

// File: rtl/csa_accum_if.sv
// Operand/result handshake bundle for csa_accum_ctrl. The out_cnt signal
// exists only when CSA_CNT_EN is defined.
interface csa_accum_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
`ifdef CSA_CNT_EN
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/csa_accum_ctrl.sv
// Carry-save stream accumulator: one 3:2 row per operand, iterative carry resolve on the last.
// Optional operand counter enabled by defining CSA_CNT_EN.
module csa_accum_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  csa_accum_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] x;
  logic             accept;

  assign x            = ACC_W'(bus.in_data);
  assign bus.in_ready = (state_q == StIdle) || (state_q == StAccum);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          s_d     = x;
          c_d     = '0;
          state_d = bus.in_last ? StResolve : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          s_d     = s_q ^ c_q ^ x;
          c_d     = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
          state_d = bus.in_last ? StResolve : StAccum;
        end
      end
      StResolve: begin
        // Result is ready once no carries remain; latch it so it survives the next group.
        if (c_q == '0) begin
          state_d     = StDone;
          out_data_d  = s_q;
          out_valid_d = 1'b1;
        end else begin
          s_d = s_q ^ c_q;
          c_d = (s_q & c_q) << 1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      s_q         <= '0;
      c_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CSA_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  assign bus.out_cnt = out_cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept && state_q == StIdle) begin
      cnt_d = CNT_W'(1);
    end else if (accept && state_q == StAccum && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == StResolve && c_q == '0) begin
      out_cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      out_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized self-checking bench for csa_accum_ctrl against a plain-arithmetic group-sum model.
module tb_csa_accum_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_accum_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_accum_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int unsigned grp[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pushes grp through the DUT, then drains the result. exp_lat < 0 only bounds the latency.
  task automatic run_group(input string tag, input int vpct, input int rpct,
                           input int exp_lat, input int hold);
    int          idx = 0;
    int          guard = 0;
    int          lat = 0;
    int unsigned sum = 0;
    int unsigned n;
    int unsigned exp_data;
    int unsigned exp_cnt;
    logic        hs;
    n = grp.size();
    foreach (grp[i]) sum += grp[i];
    exp_data = sum % 256;
    exp_cnt  = (n > 255) ? 255 : n;

    while (idx < int'(n) && guard < 4000) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.in_data  = WIDTH'(bus.in_valid ? grp[idx] : $urandom);
      bus.in_last  = bus.in_valid ? (idx == int'(n) - 1) : 1'($urandom);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) idx++;
      guard++;
    end
    if (idx != int'(n)) check_eq({tag, " accept_timeout"}, idx, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (exp_lat >= 0) check_eq({tag, " latency"}, lat, exp_lat);
    else check_eq({tag, " resolve_bound"}, (lat <= int'(ACC_W) + 1), 1);
    check_eq({tag, " data"}, bus.out_data, exp_data);
`ifdef CSA_CNT_EN
    check_eq({tag, " cnt"}, bus.out_cnt, exp_cnt);
`endif

    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = WIDTH'($urandom);
      bus.out_ready = 1'b0;
      check_eq({tag, " stall_in_ready"}, bus.in_ready, 0);
      check_eq({tag, " stall_data"}, bus.out_data, exp_data);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    guard = 0;
    while (guard < 200) begin
      bus.out_ready = ($urandom_range(99) < rpct);
      hs = bus.out_valid && bus.out_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs) break;
      check_eq({tag, " hold_valid"}, bus.out_valid, 1);
      check_eq({tag, " hold_data"}, bus.out_data, exp_data);
      guard++;
    end
    bus.out_ready = 1'b0;
    check_eq({tag, " drained"}, bus.out_valid, 0);
    check_eq({tag, " back_idle"}, bus.in_ready, 1);
    check_eq({tag, " data_kept"}, bus.out_data, exp_data);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset out_valid", bus.out_valid, 0);
    check_eq("reset out_data", bus.out_data, 0);
    check_eq("reset in_ready", bus.in_ready, 1);
`ifdef CSA_CNT_EN
    check_eq("reset out_cnt", bus.out_cnt, 0);
`endif
    rst = 1'b0;

    grp = '{3, 5, 7};
    run_group("t1", 100, 100, 2, 0);

    grp = '{9};
    run_group("t2", 100, 100, 1, 0);

    grp.delete();
    repeat (18) grp.push_back(15);
    run_group("t3", 100, 100, -1, 0);

    grp = '{4};
    run_group("t4a", 100, 100, -1, 10);
    grp = '{1, 2};
    run_group("t4b", 100, 100, -1, 0);

    // Reset in the middle of a group discards it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd2;
    bus.in_last  = 1'b0;
    @(negedge clk);
    bus.in_data  = 4'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_eq("t5 rst out_valid", bus.out_valid, 0);
    check_eq("t5 rst out_data", bus.out_data, 0);
    check_eq("t5 rst in_ready", bus.in_ready, 1);
`ifdef CSA_CNT_EN
    check_eq("t5 rst out_cnt", bus.out_cnt, 0);
`endif
    rst = 1'b0;
    grp = '{6};
    run_group("t5", 100, 100, 1, 0);

    for (int g = 0; g < 30; g++) begin
      int unsigned n;
      n = $urandom_range(40, 1);
      grp.delete();
      for (int k = 0; k < int'(n); k++) grp.push_back($urandom_range(15));
      run_group("t6", 70, 60, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
